// File: rtl/tmds_channel_decoder.sv
// TMDS channel receive decoder: bitslip-driven word alignment, 8b/10b data and control token decode.
// Optional 16-bit short-run error counter (O_err_cnt) when TMDS_DEC_ERRCNT_EN is defined.
module tmds_channel_decoder #(
    parameter int LOCK_RUN     = 8,
    parameter int SEARCH_WIN   = 4096,
    parameter int SLIP_WAIT    = 4,
    parameter int LOST_TIMEOUT = 4096,
    parameter int MIN_CTRL_RUN = 12
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [9:0]  I_symbol,
    output logic        O_bitslip,
    output logic        O_locked,
    output logic        O_de,
    output logic [7:0]  O_data,
    output logic [1:0]  O_ctrl,
    output logic        O_err
`ifdef TMDS_DEC_ERRCNT_EN
    ,
    output logic [15:0] O_err_cnt
`endif
);
    // state  | meaning
    // SEARCH | hunting for LOCK_RUN identical consecutive control tokens
    // SLIP   | one-cycle bitslip pulse to the deserializer
    // WAIT   | deserializer settle time, input ignored
    // LOCKED | aligned; decoding data and control tokens
    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_SLIP   = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_LOCKED = 2'd3;

    localparam int RUN_W  = $clog2(LOCK_RUN + 1);
    localparam int WIN_W  = $clog2(SEARCH_WIN + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int TO_W   = $clog2(LOST_TIMEOUT + 1);
    localparam int CRUN_W = $clog2(MIN_CTRL_RUN + 1);

    logic [9:0]        sym_q;
    logic [1:0]        state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [CRUN_W-1:0] crun_q, crun_d;
    logic [1:0]        last_q, last_d;
    logic              first_q, first_d;
    logic              de_q, de_d;
    logic [7:0]        data_q, data_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              err_q, err_d;
    logic              is_ctrl;
    logic [1:0]        ctrl_val;
    logic [7:0]        d_raw, dec;

    always_comb begin
        is_ctrl  = 1'b1;
        ctrl_val = 2'b00;
        case (sym_q)
            10'h354: ctrl_val = 2'b00;
            10'h0AB: ctrl_val = 2'b01;
            10'h154: ctrl_val = 2'b10;
            10'h2AB: ctrl_val = 2'b11;
            default: is_ctrl = 1'b0;
        endcase
    end

    always_comb begin
        d_raw  = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
        dec    = '0;
        dec[0] = d_raw[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym_q[8] ? (d_raw[i] ^ d_raw[i-1]) : ~(d_raw[i] ^ d_raw[i-1]);
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = '0;
        win_d   = '0;
        wait_d  = '0;
        to_d    = '0;
        last_d  = last_q;
        case (state_q)
            S_SEARCH: begin
                win_d = win_q + WIN_W'(1);
                if (is_ctrl) begin
                    last_d = ctrl_val;
                    run_d  = (run_q != '0 && ctrl_val == last_q) ? run_q + RUN_W'(1) : RUN_W'(1);
                end
                // a completed run takes priority over an expiring window
                if (run_d == RUN_W'(LOCK_RUN)) begin
                    state_d = S_LOCKED;
                end else if (win_q == WIN_W'(SEARCH_WIN - 1)) begin
                    state_d = S_SLIP;
                end
            end
            S_SLIP: state_d = S_WAIT;
            S_WAIT: begin
                wait_d = wait_q + WAIT_W'(1);
                if (wait_q == WAIT_W'(SLIP_WAIT - 1)) begin
                    state_d = S_SEARCH;
                end
            end
            S_LOCKED: begin
                if (!is_ctrl) begin
                    to_d = to_q + TO_W'(1);
                    if (to_q == TO_W'(LOST_TIMEOUT - 1)) begin
                        state_d = S_SEARCH;
                    end
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    // the run that produced lock is never judged short
    always_comb begin
        crun_d  = '0;
        first_d = 1'b1;
        err_d   = 1'b0;
        if (state_q == S_LOCKED) begin
            first_d = first_q;
            if (is_ctrl) begin
                crun_d = (crun_q == CRUN_W'(MIN_CTRL_RUN)) ? crun_q : crun_q + CRUN_W'(1);
            end else begin
                first_d = 1'b0;
                err_d   = (state_d == S_LOCKED) && !first_q && (crun_q != '0)
                          && (crun_q < CRUN_W'(MIN_CTRL_RUN));
            end
        end
    end

    always_comb begin
        de_d   = 1'b0;
        data_d = '0;
        ctrl_d = '0;
        if (state_d == S_LOCKED) begin
            ctrl_d = ctrl_q;
            if (is_ctrl) begin
                ctrl_d = ctrl_val;
            end else begin
                de_d   = 1'b1;
                data_d = dec;
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            sym_q   <= '0;
            state_q <= S_SEARCH;
            run_q   <= '0;
            win_q   <= '0;
            wait_q  <= '0;
            to_q    <= '0;
            crun_q  <= '0;
            last_q  <= '0;
            first_q <= 1'b1;
            de_q    <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            sym_q   <= I_symbol;
            state_q <= state_d;
            run_q   <= run_d;
            win_q   <= win_d;
            wait_q  <= wait_d;
            to_q    <= to_d;
            crun_q  <= crun_d;
            last_q  <= last_d;
            first_q <= first_d;
            de_q    <= de_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
        end
    end

`ifdef TMDS_DEC_ERRCNT_EN
    logic [15:0] ecnt_q;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            ecnt_q <= '0;
        end else if (state_d == S_SEARCH && state_q != S_SEARCH) begin
            ecnt_q <= '0;
        end else if (err_d && ecnt_q != 16'hFFFF) begin
            ecnt_q <= ecnt_q + 16'd1;
        end
    end

    assign O_err_cnt = ecnt_q;
`endif

    assign O_bitslip = (state_q == S_SLIP);
    assign O_locked  = (state_q == S_LOCKED);
    assign O_de      = de_q;
    assign O_data    = data_q;
    assign O_ctrl    = ctrl_q;
    assign O_err     = err_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Testbench for tmds_channel_decoder: scoreboard of expected outputs, 2-cycle output latency.
// Honours TMDS_DEC_ERRCNT_EN for the optional error counter port.
module tb_tmds_channel_decoder;
    localparam int LOCK_RUN     = 8;
    localparam int SEARCH_WIN   = 4096;
    localparam int SLIP_WAIT    = 4;
    localparam int LOST_TIMEOUT = 4096;
    localparam int MIN_CTRL_RUN = 12;
    localparam int SLIP_PERIOD  = SEARCH_WIN + SLIP_WAIT + 1;

    logic       I_clk = 1'b0;
    logic       I_rst;
    logic [9:0] I_symbol;
    logic       O_bitslip, O_locked, O_de, O_err;
    logic [7:0] O_data;
    logic [1:0] O_ctrl;
`ifdef TMDS_DEC_ERRCNT_EN
    logic [15:0] O_err_cnt;
`endif

    tmds_channel_decoder #(
        .LOCK_RUN     (LOCK_RUN),
        .SEARCH_WIN   (SEARCH_WIN),
        .SLIP_WAIT    (SLIP_WAIT),
        .LOST_TIMEOUT (LOST_TIMEOUT),
        .MIN_CTRL_RUN (MIN_CTRL_RUN)
    ) dut (
        .I_clk     (I_clk),
        .I_rst     (I_rst),
        .I_symbol  (I_symbol),
        .O_bitslip (O_bitslip),
        .O_locked  (O_locked),
        .O_de      (O_de),
        .O_data    (O_data),
        .O_ctrl    (O_ctrl),
        .O_err     (O_err)
`ifdef TMDS_DEC_ERRCNT_EN
        ,
        .O_err_cnt (O_err_cnt)
`endif
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] st_sym[$];
    exp_t       st_exp[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         err_seen = 0;

    function automatic logic [9:0] tmds_enc(input logic [7:0] b, input bit use_xor, input bit inv);
        logic [8:0] qm;
        qm[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xor ? (qm[i-1] ^ b[i]) : ~(qm[i-1] ^ b[i]);
        end
        qm[8] = use_xor;
        return {inv, qm[8], (inv ? ~qm[7:0] : qm[7:0])};
    endfunction

    function automatic bit is_ctrl_code(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    // word seen by a deserializer whose boundary is o bits into a repeating token stream
    function automatic logic [9:0] rot_word(input logic [9:0] tok, input int o);
        logic [9:0] w;
        for (int j = 0; j < 10; j++) begin
            w[j] = tok[(j + o) % 10];
        end
        return w;
    endfunction

    task automatic add(input logic [9:0] sym, input logic de, input logic [7:0] data,
                       input logic [1:0] ctrl, input logic err);
        exp_t e;
        e.de = de; e.data = data; e.ctrl = ctrl; e.err = err;
        st_sym.push_back(sym);
        st_exp.push_back(e);
    endtask

    task automatic add_rand_data(input logic [1:0] ctrl);
        logic [7:0] b;
        logic [9:0] w;
        b = 8'hFF;
        w = 10'h0FF;
        for (int t = 0; t < 16; t++) begin
            b = 8'($urandom_range(0, 255));
            w = tmds_enc(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (!is_ctrl_code(w)) break;
        end
        if (is_ctrl_code(w)) begin
            b = 8'hFF;
            w = 10'h0FF;
        end
        add(w, 1'b1, b, ctrl, 1'b0);
    endtask

    task automatic add_lock(input logic [9:0] tok, input logic [1:0] val);
        for (int i = 0; i < LOCK_RUN; i++) begin
            add(tok, 1'b0, 8'h00, (i == LOCK_RUN - 1) ? val : 2'b00, 1'b0);
        end
    endtask

    task automatic apply_reset();
        I_rst = 1'b1;
        repeat (2) begin
            I_symbol = 10'($urandom_range(0, 1023));
            @(posedge I_clk); #1;
        end
        I_rst = 1'b0;
        sb.delete();
        st_sym.delete();
        st_exp.delete();
    endtask

    task automatic test_reset();
        I_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            I_symbol = 10'($urandom_range(0, 1023));
            @(posedge I_clk); #1;
            n_checks++;
            if ({O_bitslip, O_locked, O_de, O_data, O_ctrl, O_err} !== 14'd0) begin
                n_errors++;
                $display("FAIL reset[%0d]: got slip=%0b lock=%0b de=%0b data=%02h ctrl=%02b err=%0b, want all 0",
                         i, O_bitslip, O_locked, O_de, O_data, O_ctrl, O_err);
            end
`ifdef TMDS_DEC_ERRCNT_EN
            n_checks++;
            if (O_err_cnt !== 16'd0) begin
                n_errors++;
                $display("FAIL reset_errcnt: got %0d, want 0", O_err_cnt);
            end
`endif
        end
        I_rst = 1'b0;
    endtask

    task automatic test_aligned_decode();
        exp_t e;
        apply_reset();
        add_lock(10'h354, 2'b00);
        add(10'h0FF, 1'b1, 8'hFF, 2'b00, 1'b0);
        add(10'h100, 1'b1, 8'h00, 2'b00, 1'b0);
        add(10'h3FF, 1'b1, 8'h00, 2'b00, 1'b0);
        for (int i = 0; i < 6; i++) add_rand_data(2'b00);
        for (int i = 0; i <= st_sym.size(); i++) begin
            if (i < st_sym.size()) begin
                I_symbol = st_sym[i];
                sb.push_back(st_exp[i]);
            end
            @(posedge I_clk); #1;
            if (i == LOCK_RUN - 1) begin
                n_checks++;
                if (O_locked !== 1'b0) begin
                    n_errors++;
                    $display("FAIL aligned_early_lock: got locked=%0b, want 0", O_locked);
                end
            end
            if (i == LOCK_RUN) begin
                n_checks++;
                if (O_locked !== 1'b1) begin
                    n_errors++;
                    $display("FAIL aligned_lock: got locked=%0b, want 1", O_locked);
                end
            end
            if (i > 0 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({O_de, O_data, O_ctrl, O_err} !== {e.de, e.data, e.ctrl, e.err}) begin
                    n_errors++;
                    $display("FAIL aligned[%0d]: got de=%0b data=%02h ctrl=%02b err=%0b, want de=%0b data=%02h ctrl=%02b err=%0b",
                             i - 1, O_de, O_data, O_ctrl, O_err, e.de, e.data, e.ctrl, e.err);
                end
            end
        end
    endtask

    task automatic test_slip_search();
        int  o = 7;
        int  cyc = 0;
        int  slips = 0;
        int  last_slip = 0;
        bit  got_lock = 1'b0;
        apply_reset();
        while (!got_lock && cyc < 4 * SLIP_PERIOD + 200) begin
            I_symbol = rot_word(10'h154, o);
            @(posedge I_clk); #1;
            cyc++;
            if (O_bitslip) begin
                slips++;
                n_checks++;
                if (slips == 1 && cyc != SEARCH_WIN) begin
                    n_errors++;
                    $display("FAIL slip_first: got cycle %0d, want %0d", cyc, SEARCH_WIN);
                end else if (slips > 1 && cyc - last_slip != SLIP_PERIOD) begin
                    n_errors++;
                    $display("FAIL slip_spacing[%0d]: got %0d cycles, want %0d", slips, cyc - last_slip, SLIP_PERIOD);
                end
                last_slip = cyc;
                o = (o + 1) % 10;
            end
            if (O_locked) begin
                got_lock = 1'b1;
                n_checks++;
                if ({O_de, O_ctrl} !== 3'b010) begin
                    n_errors++;
                    $display("FAIL slip_lock_ctrl: got de=%0b ctrl=%02b, want de=0 ctrl=10", O_de, O_ctrl);
                end
            end
        end
        n_checks++;
        if (!got_lock || slips != 3) begin
            n_errors++;
            $display("FAIL slip_count: got lock=%0b slips=%0d, want lock=1 slips=3", got_lock, slips);
        end
    endtask

    task automatic test_lost_timeout();
        exp_t e;
        int   n;
        int   k = 0;
        int   de_seen = 0;
        bit   slipped = 1'b0;
        apply_reset();
        add_lock(10'h354, 2'b00);
        for (int j = 1; j <= LOST_TIMEOUT; j++) begin
            if (j < LOST_TIMEOUT) add(10'h0FF, 1'b1, 8'hFF, 2'b00, 1'b0);
            else                  add(10'h0FF, 1'b0, 8'h00, 2'b00, 1'b0);
        end
        n = st_sym.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                I_symbol = st_sym[i];
                sb.push_back(st_exp[i]);
            end
            @(posedge I_clk); #1;
            if (i == n - 1) begin
                n_checks++;
                if (O_locked !== 1'b1) begin
                    n_errors++;
                    $display("FAIL timeout_still_locked: got locked=%0b, want 1", O_locked);
                end
            end
            if (i == n) begin
                n_checks++;
                if (O_locked !== 1'b0) begin
                    n_errors++;
                    $display("FAIL timeout_drop: got locked=%0b, want 0", O_locked);
                end
            end
            if (i > 0 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({O_de, O_data, O_ctrl, O_err} !== {e.de, e.data, e.ctrl, e.err}) begin
                    n_errors++;
                    $display("FAIL timeout[%0d]: got de=%0b data=%02h ctrl=%02b err=%0b, want de=%0b data=%02h ctrl=%02b err=%0b",
                             i - 1, O_de, O_data, O_ctrl, O_err, e.de, e.data, e.ctrl, e.err);
                end
            end
        end
        while (!slipped && k < SEARCH_WIN + 20) begin
            @(posedge I_clk); #1;
            k++;
            if (O_de) de_seen++;
            if (O_bitslip) slipped = 1'b1;
        end
        n_checks++;
        if (!slipped || k != SEARCH_WIN) begin
            n_errors++;
            $display("FAIL timeout_slip: got slipped=%0b after %0d cycles, want slip after %0d", slipped, k, SEARCH_WIN);
        end
        n_checks++;
        if (de_seen != 0) begin
            n_errors++;
            $display("FAIL timeout_de: got %0d de cycles after drop, want 0", de_seen);
        end
    endtask

    task automatic test_short_run();
        exp_t e;
        apply_reset();
        err_seen = 0;
        add_lock(10'h354, 2'b00);
        for (int j = 0; j < 20; j++) add(10'h2AB, 1'b0, 8'h00, 2'b11, 1'b0);
        add(10'h0FF, 1'b1, 8'hFF, 2'b11, 1'b0);
        for (int j = 0; j < 5; j++) add(10'h0AB, 1'b0, 8'h00, 2'b01, 1'b0);
        add(10'h0FF, 1'b1, 8'hFF, 2'b01, 1'b1);
        for (int j = 0; j < 3; j++) add_rand_data(2'b01);
        for (int i = 0; i <= st_sym.size(); i++) begin
            if (i < st_sym.size()) begin
                I_symbol = st_sym[i];
                sb.push_back(st_exp[i]);
            end
            @(posedge I_clk); #1;
            err_seen += int'(O_err);
            if (i > 0 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({O_de, O_data, O_ctrl, O_err} !== {e.de, e.data, e.ctrl, e.err}) begin
                    n_errors++;
                    $display("FAIL short_run[%0d]: got de=%0b data=%02h ctrl=%02b err=%0b, want de=%0b data=%02h ctrl=%02b err=%0b",
                             i - 1, O_de, O_data, O_ctrl, O_err, e.de, e.data, e.ctrl, e.err);
                end
            end
        end
        n_checks++;
        if (err_seen != 1) begin
            n_errors++;
            $display("FAIL short_run_pulses: got %0d err pulses, want 1", err_seen);
        end
`ifdef TMDS_DEC_ERRCNT_EN
        n_checks++;
        if (O_err_cnt !== 16'd1) begin
            n_errors++;
            $display("FAIL short_run_errcnt: got %0d, want 1", O_err_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_data();
        exp_t e;
        apply_reset();
        add_lock(10'h354, 2'b00);
        for (int j = 0; j < 3; j++) add_rand_data(2'b00);
        for (int i = 0; i < st_sym.size(); i++) begin
            I_symbol = st_sym[i];
            @(posedge I_clk); #1;
        end
        n_checks++;
        if ({O_locked, O_de} !== 2'b11) begin
            n_errors++;
            $display("FAIL midrst_pre: got locked=%0b de=%0b, want 1 1", O_locked, O_de);
        end
        I_rst = 1'b1;
        I_symbol = 10'h0FF;
        @(posedge I_clk); #1;
        n_checks++;
        if ({O_locked, O_de, O_data} !== 10'd0) begin
            n_errors++;
            $display("FAIL midrst: got locked=%0b de=%0b data=%02h, want 0 0 00", O_locked, O_de, O_data);
        end
        I_rst = 1'b0;
        sb.delete();
        st_sym.delete();
        st_exp.delete();
        add_lock(10'h154, 2'b10);
        add(10'h100, 1'b1, 8'h00, 2'b10, 1'b0);
        for (int i = 0; i <= st_sym.size(); i++) begin
            if (i < st_sym.size()) begin
                I_symbol = st_sym[i];
                sb.push_back(st_exp[i]);
            end
            @(posedge I_clk); #1;
            if (i == LOCK_RUN) begin
                n_checks++;
                if (O_locked !== 1'b1) begin
                    n_errors++;
                    $display("FAIL midrst_relock: got locked=%0b, want 1", O_locked);
                end
            end
            if (i > 0 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({O_de, O_data, O_ctrl, O_err} !== {e.de, e.data, e.ctrl, e.err}) begin
                    n_errors++;
                    $display("FAIL midrst_relock[%0d]: got de=%0b data=%02h ctrl=%02b err=%0b, want de=%0b data=%02h ctrl=%02b err=%0b",
                             i - 1, O_de, O_data, O_ctrl, O_err, e.de, e.data, e.ctrl, e.err);
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        I_rst    = 1'b1;
        I_symbol = '0;
        test_reset();
        test_aligned_decode();
        test_slip_search();
        test_lost_timeout();
        test_short_run();
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
